// File: rtl/axis_fir_sample_source.sv
// AXI-Stream sample source for a FIR kernel's input_r port. Samples come from a small
// preloaded FIFO and are sent with an optional inter-beat gap, a sent-beat counter and a
// sticky stall-timeout flag. Define AXIS_FIR_SRC_TLAST_EN to add TLAST framing.
module axis_fir_sample_source #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FRAME_LEN      = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_overflow,
    input  logic              run,
    input  logic [7:0]        gap_cycles,
    output logic [DATA_W-1:0] input_r_TDATA,
    output logic              input_r_TVALID,
    input  logic              input_r_TREADY,
`ifdef AXIS_FIR_SRC_TLAST_EN
    output logic              input_r_TLAST,
`endif
    output logic              busy,
    output logic [31:0]       sent_count,
    output logic              blocked,
    input  logic              clear_blocked
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d, ovf_q, ovf_d;
    state_t            state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic              tvalid_q, tvalid_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [31:0]       sent_q, sent_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              blocked_q, blocked_d;
    logic              push, load, hs, can_load;

    assign push     = wr_en & ~full_q;
    assign hs       = tvalid_q & input_r_TREADY;
    assign can_load = run & (count_q != '0);

    // FIFO storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(load);
        count_d   = count_q + CW'(push) - CW'(load);
        full_d    = (count_d == CW'(DEPTH));
        ovf_d     = ovf_q | (wr_en & full_q);
        tdata_d   = load ? mem[rd_ptr_q] : tdata_q;
        sent_d    = sent_q + 32'(hs);
        stall_d   = stall_q;
        if (clear_blocked || hs)
            stall_d = '0;
        else if (tvalid_q && !input_r_TREADY && stall_q != SW'(TIMEOUT_CYCLES))
            stall_d = stall_q + SW'(1);
        blocked_d = clear_blocked ? 1'b0 : (blocked_q | (stall_d == SW'(TIMEOUT_CYCLES)));
    end

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        gap_d    = gap_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                tvalid_d = 1'b0;
                if (can_load) begin
                    load     = 1'b1;
                    tvalid_d = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (gap_cycles != 8'd0) begin
                        gap_d    = gap_cycles;
                        tvalid_d = 1'b0;
                        state_d  = GAP;
                    end else if (can_load) begin
                        load = 1'b1;
                    end else begin
                        tvalid_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            GAP: begin
                tvalid_d = 1'b0;
                // The load decision is made while the counter steps 1 -> 0 so that
                // exactly gap_cycles low cycles separate the beats.
                if (gap_q > 8'd1) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    gap_d = 8'd0;
                    if (can_load) begin
                        load     = 1'b1;
                        tvalid_d = 1'b1;
                        state_d  = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            gap_q     <= 8'd0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            sent_q    <= 32'd0;
            stall_q   <= '0;
            blocked_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            gap_q     <= gap_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            sent_q    <= sent_d;
            stall_q   <= stall_d;
            blocked_q <= blocked_d;
        end
    end

`ifdef AXIS_FIR_SRC_TLAST_EN
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [BW-1:0] beat_q, beat_d, beat_inc, load_idx;
    logic          tlast_q, tlast_d;

    // A back-to-back load happens on the handshake edge, so it takes the advanced index.
    always_comb begin
        beat_inc = (beat_q == BW'(FRAME_LEN - 1)) ? '0 : beat_q + BW'(1);
        load_idx = hs ? beat_inc : beat_q;
        beat_d   = hs ? beat_inc : beat_q;
        tlast_d  = load ? (load_idx == BW'(FRAME_LEN - 1)) : tlast_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_q  <= '0;
            tlast_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            tlast_q <= tlast_d;
        end
    end

    assign input_r_TLAST = tlast_q;
`endif

    assign wr_full        = full_q;
    assign wr_overflow    = ovf_q;
    assign input_r_TDATA  = tdata_q;
    assign input_r_TVALID = tvalid_q;
    assign busy           = (state_q != IDLE);
    assign sent_count     = sent_q;
    assign blocked        = blocked_q;

endmodule
